demux8_sched: RTL and testbench
===============================

# demux8_sched

Round-robin slot scheduler that drives the control inputs (`D`, `EN`, `sel`) of the gate-level 1-to-8 demultiplexer. A serial bit stream arrives on a valid/ready handshake. Each enabled channel receives a slot of `BURST` bits, then the scheduler moves on to the next enabled channel in round-robin order. It is the sequencing layer between a serial source and the eight demux outputs.

## Interface
- `BURST`, default 4: bits per channel slot; legal range 1..16.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `mask`  in  8  channel enables; bit i set means channel i takes part in the rotation
- `din`  in  1  serial data bit
- `din_valid`  in  1  `din` is valid this cycle
- `din_ready`  out  1  scheduler accepts `din` this cycle
- `D`  out  1  demux data input (registered)
- `EN`  out  1  demux enable (registered, one-cycle pulse per bit)
- `sel`  out  3  demux channel select (registered)
- `slot_done`  out  1  one-cycle pulse with the last bit of a slot
- `idle`  out  1  high while in IDLE

## Operation
- States: IDLE and RUN. Internal registers:
  - `cur[2:0]`: active channel.
  - `ptr[2:0]`: search start.
  - `cnt`: 4-bit bit count within the slot.
- A transfer occurs when `din_valid & din_ready`.
- Channel search from start s: the first channel c = s, s+1, … (mod 8) with `mask[c]=1`. All 8 positions are checked, wrapping.
- IDLE:
  - `din_ready=0`, `idle=1`.
  - If `mask != 0`: `cur` <= search(`ptr`), `cnt` <= 0, next state RUN.
  - Otherwise remain in IDLE.
- RUN:
  - `din_ready=1`, `idle=0`.
  - On each transfer: `D` <= `din`, `EN` <= 1, `sel` <= `cur`, `cnt` <= `cnt`+1.
  - Last transfer of the slot (`cnt == BURST-1`):
    - `slot_done` <= 1 and `cnt` <= 0.
    - `ptr` <= `cur`+1 (mod 8).
    - If `mask != 0` this cycle: `cur` <= search(`cur`+1), stay in RUN. Where `cur` is the only enabled channel, it is selected again.
    - Otherwise go to IDLE.
- `mask` is sampled only at slot selection (the IDLE exit or the last transfer). Changes to `mask` mid-slot do not affect the current slot; that slot always completes all `BURST` bits.
- When there is no transfer in a cycle: `EN` <= 0, `D` <= 0, `slot_done` <= 0, and `sel` holds its last value.
- `BURST=1`: every transfer is a slot end.

## Timing
- Reset values:
  - State IDLE; `ptr`=0, `cur`=0, `cnt`=0.
  - `D`=0, `EN`=0, `sel`=0, `slot_done`=0, `din_ready`=0, `idle`=1.
- Reset asserted mid-slot aborts the slot. The next slot starts from channel search(0).
- IDLE→RUN costs one cycle: `mask` nonzero at edge N, `din_ready`=1 from cycle N+1.
- Latency: a transfer in cycle N produces `D`/`EN`/`sel` (and `slot_done` if last bit) valid in cycle N+1.
- Back-to-back slots have no bubble. The first bit of the next channel can transfer in the cycle after the last bit of the previous channel.
- `din_ready` and `idle` are decoded from the state register only, with no combinational path from `din_valid`.
- Throughput: one bit per cycle in RUN with `din_valid` held high.

## Test plan
- Reset, then `mask=0x01`, `BURST=4`, 8 bits `10110011` with `din_valid` held high.
  - Required: 8 consecutive `EN` pulses with `sel=0` and `D` following the stream one cycle late.
  - `slot_done` high with the 4th and 8th pulse.
- `mask=0xA4`, 12 bits with `din_valid` high.
  - Required: `sel` sequence 2,2,2,2,5,5,5,5,7,7,7,7.
  - A 13th bit goes to `sel=2`; no idle cycles between slots.
- Wrap: `mask=0x81`, start after reset.
  - Required: channel order 0,7,0.
  - `ptr` wraps from 7+1 to 0.
- Gaps: `din_valid` toggling 1,0,1,0.
  - Required: `EN` pulses only one cycle after each accepted bit.
  - `cnt` does not advance on idle cycles; the slot still ends after exactly `BURST` accepted bits.
- `mask` set to 0 after the 2nd bit of a slot.
  - Required: the slot completes with 4 pulses and `slot_done`, then `idle`=1 and `din_ready`=0 in the following cycle.
  - Reasserting `mask=0x10` leads to `sel=4` bits after one cycle.
- `rst` asserted mid-slot on channel 5 with `mask=0x30`.
  - Required: `EN`=0, `sel`=0, `idle`=1 the cycle after reset.
  - After release, the first slot is channel 4.

Source files
------------

// File: rtl/demux8_sched_if.sv
// demux8_sched_if: serial handshake and demux control bundle for demux8_sched
interface demux8_sched_if;
  logic [7:0] mask;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       D;
  logic       EN;
  logic [2:0] sel;
  logic       slot_done;
  logic       idle;
  modport master (
    output mask, din, din_valid,
    input  din_ready, D, EN, sel, slot_done, idle
  );
  modport slave (
    input  mask, din, din_valid,
    output din_ready, D, EN, sel, slot_done, idle
  );
endinterface

// File: rtl/demux8_sched.sv
// demux8_sched: round-robin slot scheduler driving D/EN/sel of a 1-to-8 demux
module demux8_sched #(
  parameter int unsigned BURST = 4
) (
  input logic           clk,
  input logic           rst,
  demux8_sched_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state_q, state_d;
  logic [2:0] cur_q, cur_d, ptr_q, ptr_d, sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       d_q, d_d, en_q, en_d, done_q, done_d;
  logic       xfer, last, any;
  // first enabled channel at or after s, wrapping; scanning downward lets the nearest one win
  function automatic logic [2:0] search(input logic [7:0] m, input logic [2:0] s);
    logic [2:0] c;
    search = s;
    for (int k = 7; k >= 0; k--) begin
      c = s + 3'(k);
      if (m[c]) search = c;
    end
  endfunction
  always_comb begin
    any     = |bus.mask;
    xfer    = bus.din_valid && state_q == RUN;
    last    = xfer && cnt_q == 4'(BURST - 1);
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    cnt_d   = xfer ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
    if (state_q == IDLE && any) begin
      state_d = RUN;
      cur_d   = search(bus.mask, ptr_q);
      cnt_d   = '0;
    end
    if (last) begin
      ptr_d   = cur_q + 3'd1;
      cur_d   = any ? search(bus.mask, cur_q + 3'd1) : cur_q;
      state_d = any ? RUN : IDLE;
    end
    d_d    = xfer & bus.din;
    en_d   = xfer;
    sel_d  = xfer ? cur_q : sel_q;
    done_d = last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      d_q     <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end
  assign bus.D         = d_q;
  assign bus.EN        = en_q;
  assign bus.sel       = sel_q;
  assign bus.slot_done = done_q;
  assign bus.din_ready = state_q == RUN;
  assign bus.idle      = state_q == IDLE;
endmodule

// File: tb/tb_demux8_sched.sv
// tb_demux8_sched: directed scenario tests for demux8_sched with BURST=4
module tb_demux8_sched;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  demux8_sched_if bus ();
  demux8_sched #(.BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic do_reset();
    rst = 1'b1;
    bus.mask = 8'h00;
    bus.din = 1'b0;
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.D, bus.EN, bus.sel, bus.slot_done, bus.din_ready, bus.idle} !== 8'b0_0_000_0_0_1) begin
      bad++;
      $display("FAIL reset: D EN sel done ready idle = %b %b %0d %b %b %b, want 0 0 0 0 0 1",
               bus.D, bus.EN, bus.sel, bus.slot_done, bus.din_ready, bus.idle);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.idle !== 1'b1 || bus.din_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_mask0: idle=%b ready=%b, want 1 0", bus.idle, bus.din_ready);
    end
  endtask
  task automatic test_single();
    logic [7:0] stream = 8'b10110011;
    do_reset();
    bus.mask = 8'h01;
    @(negedge clk);
    total++;
    if (bus.din_ready !== 1'b1 || bus.idle !== 1'b0) begin
      bad++;
      $display("FAIL single_enter: ready=%b idle=%b, want 1 0", bus.din_ready, bus.idle);
    end
    for (int i = 0; i < 8; i++) begin
      bus.din = stream[7 - i];
      bus.din_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.EN !== 1'b1 || bus.D !== stream[7 - i] || bus.sel !== 3'd0 || bus.slot_done !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL single_bit%0d: EN=%b D=%b sel=%0d done=%b, want 1 %b 0 %b",
                 i, bus.EN, bus.D, bus.sel, bus.slot_done, stream[7 - i], i % 4 == 3);
      end
    end
    bus.din_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.EN !== 1'b0 || bus.D !== 1'b0 || bus.sel !== 3'd0) begin
      bad++;
      $display("FAIL single_after: EN=%b D=%b sel=%0d, want 0 0 0", bus.EN, bus.D, bus.sel);
    end
  endtask
  task automatic test_rr(input logic [7:0] m, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] c3, input string nm);
    logic [2:0] chans [4];
    chans = '{c0, c1, c2, c3};
    do_reset();
    bus.mask = m;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      bus.din = i[0];
      bus.din_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.EN !== 1'b1 || bus.D !== i[0] || bus.sel !== chans[i / 4] || bus.slot_done !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL %s_bit%0d: EN=%b D=%b sel=%0d done=%b, want 1 %b %0d %b",
                 nm, i, bus.EN, bus.D, bus.sel, bus.slot_done, i[0], chans[i / 4], i % 4 == 3);
      end
    end
    bus.din_valid = 1'b0;
  endtask
  task automatic test_gaps();
    int acc = 0;
    do_reset();
    bus.mask = 8'h01;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.din = 1'b1;
      bus.din_valid = (i % 2 == 0);
      @(negedge clk);
      if (i % 2 == 0) acc++;
      total++;
      if (bus.EN !== (i % 2 == 0) || bus.D !== (i % 2 == 0) || bus.slot_done !== (i == 6)) begin
        bad++;
        $display("FAIL gaps_cyc%0d: EN=%b D=%b done=%b, want %b %b %b",
                 i, bus.EN, bus.D, bus.slot_done, i % 2 == 0, i % 2 == 0, i == 6);
      end
    end
    bus.din_valid = 1'b0;
    total++;
    if (acc != 4 || bus.din_ready !== 1'b1) begin
      bad++;
      $display("FAIL gaps_end: accepted=%0d ready=%b, want 4 1", acc, bus.din_ready);
    end
  endtask
  task automatic test_mask_drop();
    do_reset();
    bus.mask = 8'h03;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.din = 1'b1;
      bus.din_valid = 1'b1;
      if (i == 2) bus.mask = 8'h00;
      @(negedge clk);
      total++;
      if (bus.EN !== 1'b1 || bus.sel !== 3'd0 || bus.slot_done !== (i == 3)) begin
        bad++;
        $display("FAIL drop_bit%0d: EN=%b sel=%0d done=%b, want 1 0 %b",
                 i, bus.EN, bus.sel, bus.slot_done, i == 3);
      end
    end
    total++;
    if (bus.idle !== 1'b1 || bus.din_ready !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: idle=%b ready=%b, want 1 0", bus.idle, bus.din_ready);
    end
    @(negedge clk);
    total++;
    if (bus.EN !== 1'b0 || bus.slot_done !== 1'b0 || bus.idle !== 1'b1) begin
      bad++;
      $display("FAIL drop_hold: EN=%b done=%b idle=%b, want 0 0 1", bus.EN, bus.slot_done, bus.idle);
    end
    bus.mask = 8'h10;
    @(negedge clk);
    total++;
    if (bus.din_ready !== 1'b1 || bus.EN !== 1'b0) begin
      bad++;
      $display("FAIL drop_rearm: ready=%b EN=%b, want 1 0", bus.din_ready, bus.EN);
    end
    bus.din = 1'b0;
    @(negedge clk);
    total++;
    if (bus.EN !== 1'b1 || bus.sel !== 3'd4 || bus.D !== 1'b0) begin
      bad++;
      $display("FAIL drop_ch4: EN=%b sel=%0d D=%b, want 1 4 0", bus.EN, bus.sel, bus.D);
    end
    bus.din_valid = 1'b0;
  endtask
  task automatic test_rst_mid();
    do_reset();
    bus.mask = 8'h30;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.din = 1'b1;
      bus.din_valid = 1'b1;
      @(negedge clk);
      total++;
      if (bus.EN !== 1'b1 || bus.sel !== (i < 4 ? 3'd4 : 3'd5)) begin
        bad++;
        $display("FAIL rstmid_bit%0d: EN=%b sel=%0d, want 1 %0d", i, bus.EN, bus.sel, i < 4 ? 4 : 5);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.EN !== 1'b0 || bus.sel !== 3'd0 || bus.idle !== 1'b1 || bus.din_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_reset: EN=%b sel=%0d idle=%b ready=%b, want 0 0 1 0",
               bus.EN, bus.sel, bus.idle, bus.din_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.din_ready !== 1'b1 || bus.EN !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_rearm: ready=%b EN=%b, want 1 0", bus.din_ready, bus.EN);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.EN !== 1'b1 || bus.sel !== 3'd4 || bus.slot_done !== (i == 3)) begin
        bad++;
        $display("FAIL rstmid_after%0d: EN=%b sel=%0d done=%b, want 1 4 %b",
                 i, bus.EN, bus.sel, bus.slot_done, i == 3);
      end
    end
    bus.din_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_rr(8'hA4, 3'd2, 3'd5, 3'd7, 3'd2, "rr");
    test_rr(8'h81, 3'd0, 3'd7, 3'd0, 3'd7, "wrap");
    test_gaps();
    test_mask_drop();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
